regfile_writeback: RTL and testbench

Write-side sequencer for the 32 x 32 register file. Accepts destination/result pairs from the execute and memory stages over a valid/ready handshake, buffers them in a small in-order queue and drives one register-file write per cycle on `wb_en`/`wb_rd`/`wb_data`. Writes to register 0 are discarded. Optional forwarding ports let the decode stage see queued, not-yet-written values for `rs1`/`rs2`.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 74 +++++++
 rtl/regfile_writeback.sv | 95 +++++++++
 tb/tb_regfile_writeback.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-back entry payload for the register-file write path.
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order DEPTH x wb_entry_t queue with count, full/empty, and per-entry
// visibility (storage + occupied bits) for the forwarding compare.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  wb_entry_t             i_push_entry,
  input  logic                  i_pop,
  output wb_entry_t             o_head_c,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full_c,
  output logic                  o_empty_c,
  output logic [PTR_W-1:0]      o_rd_ptr,
  output wb_entry_t [DEPTH-1:0] o_entries_c,
  output logic [DEPTH-1:0]      o_occupied_c
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      w_offset;

  // Storage is deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    o_occupied_c = '0;
    w_offset     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_offset        = PTR_W'(PTR_W'(i) - r_rd_ptr);
      o_occupied_c[i] = (CNT_W'(w_offset) < r_count);
    end
  end

  assign o_head_c    = r_mem[r_rd_ptr];
  assign o_entries_c = r_mem;
  assign o_count     = r_count;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_full_c    = (r_count == CNT_W'(DEPTH));
  assign o_empty_c   = (r_count == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back sequencer: x0 filter, in-order queue, one write per cycle.
// Define REGFILE_WB_FORWARD_EN to build the rs1/rs2 lookup into queued writes.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wb_stall,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  wb_entry_t             w_head;
  wb_entry_t             w_push_entry;
  logic [PTR_W-1:0]      w_rd_ptr;
  wb_entry_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]      w_occupied;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign in_ready     = !w_full;
  assign w_push       = in_valid && !w_full && (in_rd != REG_ZERO);
  assign w_push_entry = '{rd: in_rd, data: in_data};
  assign wb_en        = !w_empty && !wb_stall;
  assign wb_rd        = w_empty ? '0 : w_head.rd;
  assign wb_data      = w_empty ? '0 : w_head.data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (wb_en),
    .o_head_c     (w_head),
    .o_count      (count),
    .o_full_c     (w_full),
    .o_empty_c    (w_empty),
    .o_rd_ptr     (w_rd_ptr),
    .o_entries_c  (w_entries),
    .o_occupied_c (w_occupied)
  );

`ifdef REGFILE_WB_FORWARD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = PTR_W'(w_rd_ptr + PTR_W'(k));
      if (w_occupied[w_idx] && (rs1 != REG_ZERO) && (w_entries[w_idx].rd == rs1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_entries[w_idx].data;
      end
      if (w_occupied[w_idx] && (rs2 != REG_ZERO) && (w_entries[w_idx].rd == rs2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_entries[w_idx].data;
      end
    end
  end
`else
  logic w_unused_fwd;

  assign fwd_hit1     = 1'b0;
  assign fwd_hit2     = 1'b0;
  assign fwd_data1    = '0;
  assign fwd_data2    = '0;
  assign w_unused_fwd = ^{rs1, rs2, w_rd_ptr, w_entries, w_occupied};
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef REGFILE_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wb_stall = 1'b0;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rs1 = '0;
  logic [ADDR_W-1:0] rs2 = '0;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .count(count), .rs1(rs1), .rs2(rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  wb_entry_t q[$];
  wb_entry_t pop_log[$];
  wb_entry_t wr_log[$];

  always @(posedge clk) begin
    if (!reset && wb_en) wr_log.push_back(wb_entry_t'{rd: wb_rd, data: wb_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest queued write to a nonzero register wins.
  task automatic lookup(input logic [ADDR_W-1:0] a, output bit hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (FWD && a != 0) begin
      for (int i = int'(q.size()) - 1; i >= 0; i--) begin
        if (q[i].rd == a) begin
          hit = 1'b1;
          d   = q[i].data;
          break;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d,
                       input bit st, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    in_valid = v; in_rd = rd; in_data = d; wb_stall = st; rs1 = r1; rs2 = r2;
    #1;
  endtask

  task automatic model_check();
    bit h1, h2;
    logic [DATA_W-1:0] d1, d2;
    bit nonempty;
    nonempty = (q.size() != 0);
    lookup(rs1, h1, d1);
    lookup(rs2, h2, d2);
    chk("count",    32'(count),    32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("wb_en",    32'(wb_en),    32'(nonempty && !wb_stall));
    chk("wb_rd",    32'(wb_rd),    nonempty ? 32'(q[0].rd) : 32'd0);
    chk("wb_data",  wb_data,       nonempty ? q[0].data : 32'd0);
    chk("fwd_hit1", 32'(fwd_hit1), 32'(h1));
    chk("fwd_data1", fwd_data1,    d1);
    chk("fwd_hit2", 32'(fwd_hit2), 32'(h2));
    chk("fwd_data2", fwd_data2,    d2);
  endtask

  task automatic advance();
    bit acc, pop;
    wb_entry_t e;
    acc = in_valid && (q.size() < DEPTH);
    pop = (q.size() != 0) && !wb_stall;
    e.rd   = in_rd;
    e.data = in_data;
    @(posedge clk);
    if (pop) pop_log.push_back(q.pop_front());
    if (acc && e.rd != 0) q.push_back(e);
    @(negedge clk);
  endtask

  typedef struct {
    bit v; logic [4:0] rd; logic [31:0] d; bit st; logic [4:0] r1; logic [4:0] r2;
    bit e_rdy; bit e_en; logic [4:0] e_wrd; logic [31:0] e_wd; int e_cnt;
    bit e_h1; logic [31:0] e_d1; bit e_h2; logic [31:0] e_d2;
  } vec_t;

  function automatic vec_t mk(bit v, logic [4:0] rd, logic [31:0] d, bit st, logic [4:0] r1,
                              logic [4:0] r2, bit e_en, logic [4:0] e_wrd, logic [31:0] e_wd,
                              int e_cnt, bit e_h1, logic [31:0] e_d1, bit e_h2, logic [31:0] e_d2);
    vec_t t;
    t.v = v; t.rd = rd; t.d = d; t.st = st; t.r1 = r1; t.r2 = r2;
    t.e_rdy = 1'b1; t.e_en = e_en; t.e_wrd = e_wrd; t.e_wd = e_wd; t.e_cnt = e_cnt;
    t.e_h1 = e_h1; t.e_d1 = e_d1; t.e_h2 = e_h2; t.e_d2 = e_d2;
    return t;
  endfunction

  vec_t vecs[10];

  initial begin
    int base;
    bit pending;
    logic [31:0] f10, f20, f30;
    f10 = FWD ? 32'd10 : 32'd0;
    f20 = FWD ? 32'd20 : 32'd0;
    f30 = FWD ? 32'd30 : 32'd0;
    //                v  rd  d   st r1 r2  en wrd wd  cnt h1   d1   h2   d2
    vecs[0] = mk(1, 2, 10, 0, 0, 0, 0, 0, 0,  0, 0,   0,   0,   0);
    vecs[1] = mk(0, 0, 0,  0, 2, 0, 1, 2, 10, 1, FWD, f10, 0,   0);
    vecs[2] = mk(1, 0, 99, 0, 0, 0, 0, 0, 0,  0, 0,   0,   0,   0);
    vecs[3] = mk(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,   0,   0,   0);
    vecs[4] = mk(1, 5, 20, 1, 5, 0, 0, 0, 0,  0, 0,   0,   0,   0);
    vecs[5] = mk(1, 5, 30, 1, 5, 5, 0, 5, 20, 1, FWD, f20, FWD, f20);
    vecs[6] = mk(0, 0, 0,  1, 5, 7, 0, 5, 20, 2, FWD, f30, 0,   0);
    vecs[7] = mk(0, 0, 0,  0, 5, 5, 1, 5, 20, 2, FWD, f30, FWD, f30);
    vecs[8] = mk(0, 0, 0,  0, 5, 0, 1, 5, 30, 1, FWD, f30, 0,   0);
    vecs[9] = mk(0, 0, 0,  0, 5, 0, 0, 0, 0,  0, 0,   0,   0,   0);

    // Reset values while reset is held
    @(negedge clk);
    drive(0, 0, 0, 0, 3, 4);
    model_check();
    reset = 1'b0;
    @(negedge clk);

    // Directed table: latency, x0 drop, stall, forwarding priority
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].st, vecs[i].r1, vecs[i].r2);
      chk($sformatf("t%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("t%0d_en", i),    32'(wb_en),    32'(vecs[i].e_en));
      chk($sformatf("t%0d_wrd", i),   32'(wb_rd),    32'(vecs[i].e_wrd));
      chk($sformatf("t%0d_wdata", i), wb_data,       vecs[i].e_wd);
      chk($sformatf("t%0d_count", i), 32'(count),    32'(vecs[i].e_cnt));
      chk($sformatf("t%0d_hit1", i),  32'(fwd_hit1), 32'(vecs[i].e_h1));
      chk($sformatf("t%0d_data1", i), fwd_data1,     vecs[i].e_d1);
      chk($sformatf("t%0d_hit2", i),  32'(fwd_hit2), 32'(vecs[i].e_h2));
      chk($sformatf("t%0d_data2", i), fwd_data2,     vecs[i].e_d2);
      advance();
    end

    // Continuous push/pop: count settles at 1 and pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      drive(1, 5'((i % 7) + 1), 32'(i * 3 + 1), 0, 5'(i % 8), 5'((i + 3) % 8));
      model_check();
      if (i > 0) chk("stream_count", 32'(count), 32'd1);
      advance();
    end
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      advance();
    end

    // Stall fill: four pushes fill the queue, fifth waits for space
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(10 + i), 32'(100 + i), 1, 5'(10 + i), 0);
      model_check();
      advance();
    end
    drive(1, 5'd14, 32'd104, 1, 0, 0);
    model_check();
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    advance();
    base    = wr_log.size();
    pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pending, 5'd14, 32'd104, 0, 5'd14, 5'd12);
      model_check();
      if (q.size() < DEPTH) pending = 1'b0;
      advance();
    end
    chk("release_writes", 32'(wr_log.size() - base), 32'd4);
    if (wr_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) chk("release_order", 32'(wr_log[base + i].rd), 32'(10 + i));
    end
    chk("fifth_accepted", 32'(pending), 32'd0);
    for (int i = 0; i < 6 && q.size() != 0; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      advance();
    end

    // Mid-operation reset drops queued writes and kills wb_en asynchronously
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 32'(200 + i), 1, 0, 0);
      model_check();
      advance();
    end
    drive(0, 0, 0, 0, 5'd21, 0);
    model_check();
    reset = 1'b1;
    #1;
    q.delete();
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_hit1",  32'(fwd_hit1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 5'd21, 0);
    model_check();
    advance();

    // Random traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 35, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      model_check();
      advance();
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      model_check();
      advance();
    end
    chk("drained", 32'(q.size()), 32'd0);

    // Every write the model retired must appear once, in order, at the register file
    chk("log_size", 32'(wr_log.size()), 32'(pop_log.size()));
    for (int i = 0; i < wr_log.size() && i < pop_log.size(); i++) begin
      if (wr_log[i] !== pop_log[i]) begin
        chk($sformatf("log_%0d", i), 32'(wr_log[i].rd), 32'(pop_log[i].rd));
        chk($sformatf("logd_%0d", i), wr_log[i].data, pop_log[i].data);
      end else begin
        n_checks++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
